// File: rtl/mem_access_unit.sv
// Fixed-latency wait-state memory for the multicycle core: a single-cycle request
// is accepted in IDLE, held WAIT_CYCLES cycles, and committed on entry to DONE.
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_lat;
  logic [DATA_W-1:0]     wdata_lat;
  logic                  wr_lat;
  logic                  err_lat;
  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];

  logic                  req;
  logic                  commit;
  logic                  commit_wr;
  logic [DEPTH_LOG2-1:0] commit_idx;
  logic [DATA_W-1:0]     commit_wdata;
  logic                  unused_addr_hi;

  assign req            = rd_req | wr_req;
  assign unused_addr_hi = ^addr[ADDR_W-1:DEPTH_LOG2+2];

  // With zero wait the accepting edge is also the commit edge, so operands
  // come straight from the inputs instead of the latches.
  always_comb begin
    commit       = 1'b0;
    commit_wr    = wr_lat;
    commit_idx   = idx_lat;
    commit_wdata = wdata_lat;
    if (state == IDLE) begin
      commit       = ZERO_WAIT && req;
      commit_wr    = wr_req;
      commit_idx   = addr[DEPTH_LOG2+1:2];
      commit_wdata = wdata;
    end else if (state == WAIT) begin
      commit = (cnt == 4'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rdata     <= '0;
      idx_lat   <= '0;
      wdata_lat <= '0;
      wr_lat    <= 1'b0;
      err_lat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx_lat   <= addr[DEPTH_LOG2+1:2];
            wdata_lat <= wdata;
            wr_lat    <= wr_req;
            err_lat   <= (addr[1:0] != 2'b00) || (rd_req && wr_req);
            if (ZERO_WAIT) begin
              state <= DONE;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) state <= DONE;
          else             cnt   <= cnt - 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit && !commit_wr) rdata <= mem[commit_idx];
    end
  end

  // Memory is deliberately not reset; a reset edge must never commit a write.
  always_ff @(posedge clk) begin
    if (commit && commit_wr && !rst) mem[commit_idx] <= commit_wdata;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = (state == DONE) && err_lat;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Wait-state memory block for the multicycle RISC-V core. It sits directly downstream of the main controller's memory strobes and the datapath address mux, and holds the unified instruction/data word memory. It turns single-cycle read/write requests into a fixed-latency access. It returns busy/done so the controller can hold its fetch and memory states until data is valid.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, word width
DEPTH_LOG2, 10, log2 of the number of words stored (1024)
WAIT_CYCLES, 2, extra latency cycles per access; legal range 0..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
rd_req  input  1  read request strobe, sampled only in IDLE
wr_req  input  1  write request strobe, sampled only in IDLE
addr  input  ADDR_W  byte address; word index = addr[DEPTH_LOG2+1:2]
wdata  input  DATA_W  write data
rdata  output  DATA_W  registered read data
busy  output  1  access in progress (state WAIT or DONE)
done  output  1  one-cycle completion pulse
err  output  1  one-cycle error flag, coincident with done

Behaviour:
- Reset: async rst forces state=IDLE, cnt=0, rdata=0, busy=0, done=0, err=0. Reset does not clear memory contents; their power-up value is X.
- Reset mid-operation: the pending access is abandoned. A pending write is never committed. rdata is cleared to 0.
- States: IDLE, WAIT, DONE. busy=1 in WAIT and DONE. done=1 and err (if latched) only in DONE. All outputs are registered or state-decoded, with no combinational path from inputs.
- IDLE:
  - If rd_req or wr_req is high at the edge, latch addr, wdata, op and err_lat.
  - If WAIT_CYCLES=0, go to DONE; otherwise go to WAIT with cnt=WAIT_CYCLES.
  - With no request, stay in IDLE.
- WAIT: at each edge, if cnt==1 go to DONE, else cnt=cnt-1. Inputs are ignored.
- Entry into DONE (commit edge):
  - A write stores latched wdata at the latched word index.
  - A read captures mem[index] into rdata.
- DONE: lasts exactly one cycle, then goes to IDLE unconditionally. Requests presented in DONE are ignored; the controller must re-present the request.
- Latency: done is high in the cycle after the (WAIT_CYCLES+1)-th rising edge, counting the accepting edge as the first.
- Throughput: at most one access per WAIT_CYCLES+2 cycles.
- rdata: holds its value until the next completed read. Writes never modify rdata.
- err_lat is set when either of these holds at accept:
  - addr[1:0]!=0: the access is still performed at the word index, with low bits ignored.
  - rd_req and wr_req are both high: the write is performed and rdata is unchanged.
- Address bits above DEPTH_LOG2+1 are ignored, so addresses alias modulo 4·2^DEPTH_LOG2 bytes. This is not an error.
- Inputs changing during WAIT have no effect, because all access operands are latched at accept.

Test Plan:
- Reset, then WAIT_CYCLES=2: write 0xDEADBEEF to addr 0x10 -> busy high for 3 cycles, done pulses once, 3 edges after accept; rdata stays 0.
- Read from 0x10 -> done 3 edges after accept with rdata=0xDEADBEEF; rdata holds through the next 5 idle cycles.
- Hold rd_req high continuously -> accepts occur exactly every 4 cycles (WAIT_CYCLES+2); no request is taken during WAIT or DONE.
- Write 0x12345678 to 0x22 -> err=1 with done; a read of 0x20 returns 0x12345678.
- rd_req and wr_req both high, addr 0x30, wdata 0xA5A5A5A5 -> err=1 and rdata unchanged; a later read of 0x30 returns 0xA5A5A5A5.
- Alias and reset cases:
  - Write 0x11 to 0x1004 (DEPTH_LOG2=10), then read 0x0004 -> 0x11.
  - Start a write of 0x77 to 0x40 and assert rst during WAIT -> immediate IDLE, busy=0, done never pulses; a read of 0x40 returns the old value.
  - Repeat all of the above with WAIT_CYCLES=0 -> done occurs one edge after accept.
